mem_responder: RTL

Registered bus responder for the executor's memory interface: holds 2**M words of N bits and answers one read or write per request with a programmable number of wait states. It is the responder end of the executor's Select/RW/Data bus. Data is split into separate write and read buses, and an explicit Request/Ready handshake is added so the executor can tolerate slow memories. It sits in the computer top between the executor and the backing storage.

---
 rtl/mem_responder.sv | 110 +++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// mem_responder: registered memory responder with a Request/Ready handshake
// and a fixed number of wait states per transaction.
module mem_responder #(
    parameter int unsigned N    = 8,
    parameter int unsigned M    = 2,
    parameter int unsigned WAIT = 1
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         Request,
    input  logic         RW,
    input  logic [M-1:0] Select,
    input  logic [N-1:0] WriteData,
    output logic [N-1:0] ReadData,
    output logic         Ready,
    output logic         Busy,
    output logic [7:0]   TxnCount
);

    typedef enum logic [1:0] {
        IDLE,
        WAITING,
        RESPOND
    } state_t;

    localparam logic [3:0] WAIT_M1 = 4'((WAIT == 0) ? 0 : WAIT - 1);

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [M-1:0]   sel_q, sel_d;
    logic           rw_q, rw_d;
    logic [N-1:0]   wdata_q, wdata_d;
    logic [N-1:0]   rdata_q;
    logic           ready_q;
    logic           busy_q;
    logic [7:0]     txn_q;
    logic [N-1:0]   mem_q [2**M];
    logic           done;

    // Next-state logic: accept in IDLE, count down in WAITING, one RESPOND cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (Request) begin
                    sel_d   = Select;
                    rw_d    = RW;
                    wdata_d = WriteData;
                    cnt_d   = WAIT_M1;
                    state_d = (WAIT != 0) ? WAITING : RESPOND;
                end
            end
            WAITING: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESPOND;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The RESPOND cycle's effects are registered, so they land on the edge
    // leaving RESPOND; this gives Ready at acceptance + WAIT + 1.
    assign done = (state_q == RESPOND);

    // State, latched request, storage and registered outputs.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            txn_q   <= '0;
            mem_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            ready_q <= done;
            busy_q  <= (state_d != IDLE);
            if (done) begin
                txn_q <= txn_q + 8'd1;
                if (rw_q) begin
                    mem_q[sel_q] <= wdata_q;
                end else begin
                    rdata_q <= mem_q[sel_q];
                end
            end
        end
    end

    assign ReadData = rdata_q;
    assign Ready    = ready_q;
    assign Busy     = busy_q;
    assign TxnCount = txn_q;

endmodule
